axi_arb_rr_hold: RTL and testbench

Parametrised N-master request arbiter for the AXI node request channels (AW/AR). Supports any master count, not only powers of two. Arbitration is fair round-robin with an AXI-compliant hold: once an offer is on the output, its selection is frozen until the handshake completes. Provides an exclusive-lock override, optional master-index ID extension, and an optional full-throughput output register stage. It sits between the per-slave request fan-in and the slave port.

---
 rtl/axi_arb_pkg.sv | 15 +
 rtl/axi_arb_spill_reg.sv | 47 ++++
 rtl/axi_arb_rr_hold.sv | 134 +++++++++++++
 tb/tb_axi_arb_rr_hold.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// Shared types and helpers for the round-robin request arbiter.
// Holds the arbiter FSM encoding and the modulo-N index increment.
package axi_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } arb_state_e;

   // Explicit wrap so non-power-of-two master counts stay in range
   function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
      return (idx >= n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/axi_arb_spill_reg.sv
// Two-entry valid/ready register: one beat per cycle, one cycle latency.
// in_rdy depends only on local state, so out_rdy never reaches in_rdy combinationally.
module axi_arb_spill_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_vld,
   input  logic [WIDTH-1:0] in_dat,
   output logic             in_rdy,
   output logic             out_vld,
   output logic [WIDTH-1:0] out_dat,
   input  logic             out_rdy
);

   logic             a_vld_q, b_vld_q;
   logic [WIDTH-1:0] a_dat_q, b_dat_q;
   logic             in_hs;

   assign in_rdy  = ~b_vld_q;
   assign in_hs   = in_vld & ~b_vld_q;
   assign out_vld = a_vld_q;
   assign out_dat = a_dat_q;

   // Entry b only fills while entry a is stalled, so it always drains into a first
   always_ff @(posedge clk) begin
      if (rst) begin
         a_vld_q <= 1'b0;
         b_vld_q <= 1'b0;
         a_dat_q <= '0;
         b_dat_q <= '0;
      end else if (~a_vld_q | out_rdy) begin
         if (b_vld_q) begin
            a_vld_q <= 1'b1;
            a_dat_q <= b_dat_q;
            b_vld_q <= 1'b0;
         end else begin
            a_vld_q <= in_hs;
            if (in_hs) a_dat_q <= in_dat;
         end
      end else if (in_hs) begin
         b_vld_q <= 1'b1;
         b_dat_q <= in_dat;
      end
   end

endmodule

// File: rtl/axi_arb_rr_hold.sv
// Round-robin N-master AW/AR arbiter; the offer is frozen until its handshake completes.
// Zero latency with REG_OUT=0; with REG_OUT=1 one cycle latency and no gnt_i to gnt_o path.
module axi_arb_rr_hold
   import axi_arb_pkg::*;
#(
   parameter int N_MASTER     = 5,
   parameter int LOG_MASTER   = $clog2(N_MASTER),
   parameter int AUX_WIDTH    = 64,
   parameter int ID_WIDTH     = 20,
   parameter int EXTEND_ID    = 0,
   parameter int REG_OUT      = 0,
   parameter int ID_OUT_WIDTH = ID_WIDTH + EXTEND_ID * LOG_MASTER
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N_MASTER-1:0]           data_req_i,
   input  logic [N_MASTER*AUX_WIDTH-1:0] data_AUX_i,
   input  logic [N_MASTER*ID_WIDTH-1:0]  data_ID_i,
   output logic [N_MASTER-1:0]           data_gnt_o,
   output logic                          data_req_o,
   output logic [AUX_WIDTH-1:0]          data_AUX_o,
   output logic [ID_OUT_WIDTH-1:0]       data_ID_o,
   input  logic                          data_gnt_i,
   input  logic                          lock_i,
   input  logic [LOG_MASTER-1:0]         lock_sel_i
);

   arb_state_e              arb_q, arb_d;
   logic [LOG_MASTER-1:0]   ptr_q, sel_q, pick, sel;
   logic [N_MASTER-1:0]     elig;
   logic [2*N_MASTER-1:0]   elig_dbl;
   logic                    pick_vld, arb_vld, up_rdy, hs;
   logic [AUX_WIDTH-1:0]    aux_sel;
   logic [ID_WIDTH-1:0]     id_sel;
   logic [ID_OUT_WIDTH-1:0] id_ext;

   // A lock index beyond the master range matches nothing, so nobody is eligible
   always_comb begin
      elig = data_req_i;
      if (lock_i) begin
         elig = '0;
         for (int i = 0; i < N_MASTER; i++)
            if (32'(lock_sel_i) == i) elig[i] = data_req_i[i];
      end
   end

   // Scan window [ptr_q, ptr_q+N) of the doubled vector; descending loop keeps the lowest hit
   always_comb begin
      elig_dbl = {elig, elig};
      pick     = '0;
      pick_vld = 1'b0;
      for (int k = 2 * N_MASTER - 1; k >= 0; k--) begin
         if (elig_dbl[k] && k >= 32'(ptr_q) && k < 32'(ptr_q) + N_MASTER) begin
            pick_vld = 1'b1;
            pick     = LOG_MASTER'((k >= N_MASTER) ? k - N_MASTER : k);
         end
      end
   end

   assign sel     = (arb_q == HOLD) ? sel_q : pick;
   assign arb_vld = (arb_q == HOLD) ? data_req_i[sel_q] : pick_vld;
   assign hs      = arb_vld & up_rdy & ~rst;

   always_comb begin
      aux_sel    = '0;
      id_sel     = '0;
      data_gnt_o = '0;
      for (int i = 0; i < N_MASTER; i++) begin
         if (sel == LOG_MASTER'(i)) begin
            aux_sel       = data_AUX_i[i*AUX_WIDTH +: AUX_WIDTH];
            id_sel        = data_ID_i[i*ID_WIDTH +: ID_WIDTH];
            data_gnt_o[i] = hs;
         end
      end
   end

   generate
      if (EXTEND_ID != 0) begin : g_id_ext
         assign id_ext = {sel, id_sel};
      end else begin : g_id_plain
         assign id_ext = id_sel;
      end
   endgenerate

   always_comb begin
      arb_d = arb_q;
      case (arb_q)
         IDLE:    if (arb_vld && !up_rdy) arb_d = HOLD;
         HOLD:    if (hs) arb_d = IDLE;
         default: arb_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         arb_q <= IDLE;
         ptr_q <= '0;
         sel_q <= '0;
      end else begin
         arb_q <= arb_d;
         if (hs) ptr_q <= LOG_MASTER'(wrap_inc(32'(sel), N_MASTER));
         if (arb_q == IDLE && arb_d == HOLD) sel_q <= pick;
      end
   end

   generate
      if (REG_OUT != 0) begin : g_reg_out
         logic spill_vld;
         logic [ID_OUT_WIDTH+AUX_WIDTH-1:0] spill_dat;

         axi_arb_spill_reg #(
            .WIDTH(ID_OUT_WIDTH + AUX_WIDTH)
         ) u_spill (
            .clk     (clk),
            .rst     (rst),
            .in_vld  (arb_vld & ~rst),
            .in_dat  ({id_ext, aux_sel}),
            .in_rdy  (up_rdy),
            .out_vld (spill_vld),
            .out_dat (spill_dat),
            .out_rdy (data_gnt_i)
         );

         assign data_req_o = spill_vld & ~rst;
         assign {data_ID_o, data_AUX_o} = spill_dat;
      end else begin : g_comb_out
         assign up_rdy     = data_gnt_i;
         assign data_req_o = arb_vld & ~rst;
         assign data_AUX_o = aux_sel;
         assign data_ID_o  = id_ext;
      end
   endgenerate

endmodule

// File: tb/tb_axi_arb_rr_hold.sv
// Bench for axi_arb_rr_hold: combinational and registered-output instances side by side.
module tb_axi_arb_rr_hold;

   localparam int N   = 5;
   localparam int AW  = 16;
   localparam int IW  = 4;
   localparam int LM  = 3;
   localparam int IOW = IW + LM;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req;
   logic [N*AW-1:0] aux;
   logic [N*IW-1:0] id;
   logic            lock;
   logic [LM-1:0]   lock_sel;
   logic            gnt_a, gnt_b;
   logic [N-1:0]    gnt_o_a, gnt_o_b;
   logic            req_o_a, req_o_b;
   logic [AW-1:0]   aux_o_a, aux_o_b;
   logic [IOW-1:0]  id_o_a, id_o_b;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   axi_arb_rr_hold #(.N_MASTER(N), .AUX_WIDTH(AW), .ID_WIDTH(IW), .EXTEND_ID(1), .REG_OUT(0)) dut_a (
      .clk(clk), .rst(rst), .data_req_i(req), .data_AUX_i(aux), .data_ID_i(id),
      .data_gnt_o(gnt_o_a), .data_req_o(req_o_a), .data_AUX_o(aux_o_a), .data_ID_o(id_o_a),
      .data_gnt_i(gnt_a), .lock_i(lock), .lock_sel_i(lock_sel));

   axi_arb_rr_hold #(.N_MASTER(N), .AUX_WIDTH(AW), .ID_WIDTH(IW), .EXTEND_ID(1), .REG_OUT(1)) dut_b (
      .clk(clk), .rst(rst), .data_req_i(req), .data_AUX_i(aux), .data_ID_i(id),
      .data_gnt_o(gnt_o_b), .data_req_o(req_o_b), .data_AUX_o(aux_o_b), .data_ID_o(id_o_b),
      .data_gnt_i(gnt_b), .lock_i(lock), .lock_sel_i(lock_sel));

   // Reference: round-robin pointer, held master, and a plain queue for the output register
   int   m_ptr[2]  = '{0, 0};
   int   m_sel[2]  = '{0, 0};
   bit   m_hold[2] = '{0, 0};
   int   n_ptr[2], n_sel[2];
   bit   n_hold[2];
   bit   n_pop, n_push;
   logic [IOW+AW-1:0] n_dat;
   logic [IOW+AW-1:0] mq[$];
   logic [N-1:0] exp_gnt_b;

   typedef struct {
      logic          rst;
      logic [N-1:0]  req;
      logic          gnt;
      logic          lock;
      logic [LM-1:0] ls;
      logic          vld;
      logic [N-1:0]  gnt_o;
      logic [IOW-1:0] id_o;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic [N-1:0] rq, input logic g, input logic lk,
                      input logic [LM-1:0] ls, input logic v, input logic [N-1:0] go, input logic [IOW-1:0] io);
      vec_t t;
      t.rst = r; t.req = rq; t.gnt = g; t.lock = lk; t.ls = ls;
      t.vld = v; t.gnt_o = go; t.id_o = io;
      tbl.push_back(t);
   endtask

   task automatic model_eval(input int k);
      int s, c;
      bit v, up, hs, ev;
      logic [N-1:0] el;
      logic [N-1:0] eg;
      logic [LM-1:0] s3;
      v = 0; s = 0;
      if (m_hold[k]) begin
         s = m_sel[k];
         v = req[s];
      end else begin
         el = req;
         if (lock) begin
            el = '0;
            if (int'(lock_sel) < N) el[lock_sel] = req[lock_sel];
         end
         for (int j = 0; j < N; j++) begin
            c = (m_ptr[k] + j) % N;
            if (!v && el[c]) begin v = 1; s = c; end
         end
      end
      s3 = LM'(s);
      up = (k == 0) ? gnt_a : (mq.size() < 2);
      hs = v && up && !rst;
      eg = '0;
      if (hs) eg[s] = 1'b1;
      if (k == 0) begin
         ev = v && !rst;
         chk("a_gnt_model", 32'(gnt_o_a), 32'(eg));
         chk("a_req_model", 32'(req_o_a), 32'(ev));
         if (ev) begin
            chk("a_id_model", 32'(id_o_a), 32'({s3, id[s*IW +: IW]}));
            chk("a_aux_model", 32'(aux_o_a), 32'(aux[s*AW +: AW]));
         end
      end else begin
         exp_gnt_b = eg;
         ev = !rst && mq.size() > 0;
         chk("b_gnt_model", 32'(gnt_o_b), 32'(eg));
         chk("b_req_model", 32'(req_o_b), 32'(ev));
         if (ev) begin
            chk("b_id_model", 32'(id_o_b), 32'(mq[0][IOW+AW-1:AW]));
            chk("b_aux_model", 32'(aux_o_b), 32'(mq[0][AW-1:0]));
         end
         n_pop  = ev && gnt_b;
         n_push = hs;
         n_dat  = {s3, id[s*IW +: IW], aux[s*AW +: AW]};
      end
      n_ptr[k] = m_ptr[k]; n_sel[k] = m_sel[k]; n_hold[k] = m_hold[k];
      if (rst) begin
         n_ptr[k] = 0; n_sel[k] = 0; n_hold[k] = 0;
      end else if (hs) begin
         n_ptr[k] = (s + 1) % N; n_hold[k] = 0;
      end else if (v && !m_hold[k]) begin
         n_hold[k] = 1; n_sel[k] = s;
      end
   endtask

   task automatic half();
      @(negedge clk);
      model_eval(0);
      model_eval(1);
   endtask

   task automatic commit();
      @(posedge clk);
      if (rst) mq.delete();
      else begin
         if (n_pop) void'(mq.pop_front());
         if (n_push) mq.push_back(n_dat);
      end
      for (int k = 0; k < 2; k++) begin
         m_ptr[k] = n_ptr[k]; m_sel[k] = n_sel[k]; m_hold[k] = n_hold[k];
      end
      #1;
   endtask

   initial begin
      int gpat[7];
      gpat = '{1, 0, 1, 1, 1, 1, 1};

      //   rst req    g  lk ls   vld gnt_o  id_o
      add(1, 5'h1F, 1, 0, 3'd0, 0, 5'h00, 7'h00);
      add(1, 5'h1F, 1, 0, 3'd0, 0, 5'h00, 7'h00);
      add(0, 5'h1F, 1, 0, 3'd0, 1, 5'h01, 7'h05);
      add(0, 5'h1F, 1, 0, 3'd0, 1, 5'h02, 7'h16);
      add(0, 5'h1F, 1, 0, 3'd0, 1, 5'h04, 7'h27);
      add(0, 5'h1F, 1, 0, 3'd0, 1, 5'h08, 7'h38);
      add(0, 5'h1F, 1, 0, 3'd0, 1, 5'h10, 7'h4A);
      add(0, 5'h1F, 1, 0, 3'd0, 1, 5'h01, 7'h05);
      add(0, 5'h1F, 1, 1, 3'd3, 1, 5'h08, 7'h38);
      add(0, 5'h1F, 1, 1, 3'd3, 1, 5'h08, 7'h38);
      add(0, 5'h1F, 1, 1, 3'd6, 0, 5'h00, 7'h00);
      add(0, 5'h1F, 1, 1, 3'd5, 0, 5'h00, 7'h00);
      add(0, 5'h04, 0, 0, 3'd0, 1, 5'h00, 7'h27);
      add(0, 5'h06, 0, 0, 3'd0, 1, 5'h00, 7'h27);
      add(0, 5'h06, 0, 0, 3'd0, 1, 5'h00, 7'h27);
      add(0, 5'h06, 1, 0, 3'd0, 1, 5'h04, 7'h27);
      add(0, 5'h06, 1, 0, 3'd0, 1, 5'h02, 7'h16);
      add(0, 5'h10, 0, 0, 3'd0, 1, 5'h00, 7'h4A);
      add(0, 5'h11, 0, 1, 3'd0, 1, 5'h00, 7'h4A);
      add(0, 5'h11, 1, 1, 3'd0, 1, 5'h10, 7'h4A);
      add(0, 5'h11, 1, 1, 3'd0, 1, 5'h01, 7'h05);
      add(0, 5'h08, 0, 0, 3'd0, 1, 5'h00, 7'h38);
      add(0, 5'h00, 0, 0, 3'd0, 0, 5'h00, 7'h00);
      add(0, 5'h01, 1, 0, 3'd0, 0, 5'h00, 7'h00);
      add(1, 5'h09, 1, 0, 3'd0, 0, 5'h00, 7'h00);
      add(0, 5'h09, 0, 0, 3'd0, 1, 5'h00, 7'h05);
      add(0, 5'h09, 1, 0, 3'd0, 1, 5'h01, 7'h05);
      add(0, 5'h09, 1, 0, 3'd0, 1, 5'h08, 7'h38);

      rst = 1; req = '0; lock = 0; lock_sel = '0; gnt_a = 1; gnt_b = 1;
      id  = {4'hA, 4'h8, 4'h7, 4'h6, 4'h5};
      aux = {16'hA004, 16'hA003, 16'hA002, 16'hA001, 16'hA000};
      @(posedge clk); #1;

      foreach (tbl[i]) begin
         rst = tbl[i].rst; req = tbl[i].req; gnt_a = tbl[i].gnt;
         lock = tbl[i].lock; lock_sel = tbl[i].ls; gnt_b = 1;
         half();
         chk($sformatf("vec%0d_req", i), 32'(req_o_a), 32'(tbl[i].vld));
         chk($sformatf("vec%0d_gnt", i), 32'(gnt_o_a), 32'(tbl[i].gnt_o));
         if (tbl[i].vld) chk($sformatf("vec%0d_id", i), 32'(id_o_a), 32'(tbl[i].id_o));
         if (i == 2) begin
            chk("b_reset_aux", 32'(aux_o_b), 32'h0);
            chk("b_reset_id", 32'(id_o_b), 32'h0);
         end
         commit();
      end

      // Registered output: latency, stalls, and independence of gnt_o from gnt_i
      rst = 1; req = '0; lock = 0; gnt_a = 1;
      half(); commit();
      rst = 0; req = 5'h1F;
      for (int c = 0; c < 7; c++) begin
         gnt_b = gpat[c][0];
         half();
         if (c == 0) chk("b_first_latency", 32'(req_o_b), 32'h0);
         if (c == 1) begin
            chk("b_first_vld", 32'(req_o_b), 32'h1);
            chk("b_first_id", 32'(id_o_b), 32'h05);
         end
         if (c == 2 || c == 4) begin
            gnt_b = ~gnt_b; #1;
            chk("b_gnt_no_comb", 32'(gnt_o_b), 32'(exp_gnt_b));
            gnt_b = ~gnt_b; #1;
         end
         commit();
      end
      req = '0; gnt_b = 1;
      for (int c = 0; c < 4; c++) begin half(); commit(); end
      chk("b_drained", 32'(req_o_b), 32'h0);

      // Randomized traffic against the reference model
      for (int c = 0; c < 1500; c++) begin
         rst      = ($urandom_range(99) == 0);
         req      = N'($urandom);
         gnt_a    = ($urandom_range(3) != 0);
         gnt_b    = ($urandom_range(3) != 0);
         lock     = ($urandom_range(7) == 0);
         lock_sel = LM'($urandom);
         for (int m = 0; m < N; m++) begin
            aux[m*AW +: AW] = AW'($urandom);
            id[m*IW +: IW]  = IW'($urandom);
         end
         half();
         commit();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
